// File: rtl/pbdebounce_multi_pkg.sv
// Shared constants for the multi-channel push-button debouncer:
// default parameter values and the counter-width helper.
package pbdebounce_multi_pkg;

    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_HOLD_MS    = 1000;
    localparam int DEF_ACTIVE_LOW = 0;

    // Ceiling log2 of value; never returns less than 1 so a counter always has a bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(value)) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pbdebounce_ch.sv
// One push-button channel: two-flop synchroniser, sample history, debounced
// level, press/release edge pulses and a saturating hold counter that fires a
// single long-press pulse.
module pbdebounce_ch
    import pbdebounce_multi_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int HOLD_MS    = DEF_HOLD_MS,
    parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic clk_1ms,
    input  logic rst_n,
    input  logic button_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int CNT_W = clog2(HOLD_MS + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_MS);
    localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(HOLD_MS - 1);

    logic             btn_in;
    logic             s1_q, s2_q;
    logic [DEPTH-1:0] hist_q, hist_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Polarity is normalised before the synchroniser so everything downstream means 1 = pressed.
    assign btn_in = (ACTIVE_LOW != 0) ? ~button_i : button_i;

    // Next-state: shift in newest sample, accept a level only on a unanimous history.
    always_comb begin
        hist_d  = {hist_q[DEPTH-2:0], s2_q};
        level_d = level_q;
        if (&hist_d) begin
            level_d = 1'b1;
        end else if (~|hist_d) begin
            level_d = 1'b0;
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
        // Counter follows the registered level, so it starts counting the edge after the press.
        cnt_d = '0;
        if (level_q) begin
            cnt_d = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        // Only fire while still pressed, so a release on the threshold edge never yields a long press.
        long_d = level_q & level_d & (cnt_q == HOLD_PRE);
    end

    // State and output registers; reset clears everything without emitting pulses.
    always_ff @(posedge clk_1ms or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            hist_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= btn_in;
            s2_q      <= s1_q;
            hist_q    <= hist_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

endmodule

// File: rtl/pbdebounce_multi.sv
// Multi-channel push-button debouncer: CHANNELS independent copies of
// pbdebounce_ch sharing the 1 kHz sampling clock and reset.
module pbdebounce_multi
    import pbdebounce_multi_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int HOLD_MS    = DEF_HOLD_MS,
    parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic                clk_1ms,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] button_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] long_press_o
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            pbdebounce_ch #(
                .DEPTH      (DEPTH),
                .HOLD_MS    (HOLD_MS),
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_ch (
                .clk_1ms      (clk_1ms),
                .rst_n        (rst_n),
                .button_i     (button_i[gi]),
                .level_o      (level_o[gi]),
                .press_o      (press_o[gi]),
                .release_o    (release_o[gi]),
                .long_press_o (long_press_o[gi])
            );
        end
    endgenerate

endmodule

// File: doc/pbdebounce_multi.md
PBDEBOUNCE_MULTI -- requirements
Module: pbdebounce_multi

Interface
REQ-001 Parameter CHANNELS, default 4, SHALL set the number of independent push-button channels (legal 1..16).
REQ-002 Parameter DEPTH, default 8, SHALL set the number of consecutive equal samples needed to accept a level (legal 2..32).
REQ-003 Parameter HOLD_MS, default 1000, SHALL set the number of accepted-pressed clock cycles before a long-press pulse (legal 2..65535).
REQ-004 Parameter ACTIVE_LOW, default 0, SHALL invert every raw button input before synchronisation when 1.
REQ-005 clk_1ms  input  1  SHALL be the 1 kHz sampling clock; all state updates occur on its rising edge.
REQ-006 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 button  input  CHANNELS  SHALL carry the raw asynchronous button levels, one bit per channel.
REQ-008 level  output  CHANNELS  SHALL carry the registered debounced level per channel (1 = pressed).
REQ-009 press  output  CHANNELS  SHALL carry a one-cycle pulse per channel on each accepted 0->1 transition.
REQ-010 release  output  CHANNELS  SHALL carry a one-cycle pulse per channel on each accepted 1->0 transition.
REQ-011 long_press  output  CHANNELS  SHALL carry a one-cycle pulse per channel when a press has been held HOLD_MS cycles.

Function
REQ-012 Each channel SHALL pass its (optionally inverted) input through a two-flop synchroniser (s1, s2) before any other use.
REQ-013 Each channel SHALL shift s2 into a DEPTH-bit history register every edge, newest sample at bit 0.
REQ-014 level SHALL become 1 on the edge where the post-shift history is all ones, and 0 where it is all zeros; otherwise level holds.
REQ-015 Latency: a clean input step first sampled at edge 0 SHALL change level after edge DEPTH+1, exactly.
REQ-016 Any glitch shorter than DEPTH cycles SHALL NOT change level, press or release.
REQ-017 press and release SHALL be asserted on the same edge level changes, for exactly one cycle; never both on one channel in one cycle.
REQ-018 Each channel SHALL hold a hold counter of width clog2(HOLD_MS+1), cleared while level is 0, incremented each cycle while level is 1, saturating at HOLD_MS.
REQ-019 long_press SHALL pulse for one cycle on the edge the counter goes from HOLD_MS-1 to HOLD_MS; at most one pulse per press.
REQ-020 A release before the counter reaches HOLD_MS SHALL clear the counter and produce no long_press.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 All outputs SHALL be registered; no combinational path from button to any output.

Reset
REQ-023 While rst_n is 0, synchronisers, histories, level, counters, press, release and long_press SHALL all be 0, regardless of clk_1ms.
REQ-024 Reset asserted mid-press SHALL drop level to 0 without a release pulse; after deassertion a held button SHALL yield press after DEPTH+1 edges.
REQ-025 Reset deassertion SHALL be synchronised to clk_1ms by the instantiating top level; the block makes no internal reset synchroniser.

Structure
REQ-026 A per-channel sub-module pbdebounce_ch (synchroniser, history, level, counter, pulses) SHALL be instantiated CHANNELS times in a generate loop.
REQ-027 Default parameter values and the clog2 width helper SHALL live in a shared constants file included by both modules and the bench.
REQ-028 Implementation SHALL total 120-400 RTL lines across both modules.

Verification (bench: CHANNELS=4, DEPTH=8, HOLD_MS=16, ACTIVE_LOW=0)
REQ-029 Reset -> all outputs 0; button[0] held 1 from edge 0 -> level[0]=1 and press[0] one cycle after edge 9, others silent.
REQ-030 button[1] 1 for 7 cycles then 0 -> level[1], press[1], release[1] stay 0 throughout.
REQ-031 button[2] held 1 for 30 cycles -> press[2] at edge 9, long_press[2] once at edge 25, release[2] 9 edges after drop.
REQ-032 button[3] held 10 accepted cycles then released -> press then release, no long_press; counter back to 0.
REQ-033 All four channels stepped high on one edge -> press = 4'b1111 for exactly one cycle at edge 9.
REQ-034 rst_n pulsed low mid-press on channel 0 -> immediate 0 outputs, no release; button still high -> press again DEPTH+1 edges after rst_n rises; repeat with ACTIVE_LOW=1 and inverted stimulus, same responses.
